// File: rtl/pipe_pkg.sv
// Shared types and constants for the five-stage pipeline sequencing controller.
// Used by pipe_hazard_detect and pipe_hazard_ctrl.
package pipe_pkg;

  localparam int REG_AW = 4;

  // Encoding the inter-stage latches substitute when flushed or bubbled.
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_STARTUP  = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_of_en;
    logic of_ex_en;
    logic ex_ma_en;
    logic ma_rw_en;
    logic if_of_flush;
    logic of_ex_bubble;
    logic ex_ma_bubble;
    logic ma_rw_bubble;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_FILL   = 9'b0_1111_1111;
  localparam pipe_ctl_t CTL_PASS   = 9'b1_1111_0000;
  localparam pipe_ctl_t CTL_STALL  = 9'b0_0111_0100;
  localparam pipe_ctl_t CTL_BRANCH = 9'b1_1111_1100;
  localparam pipe_ctl_t CTL_HOLD   = 9'b0_0000_0000;

  function automatic logic src_match(
    input logic [REG_AW-1:0] rs,
    input logic              rs_vld,
    input logic [REG_AW-1:0] rd,
    input logic              wb
  );
    return rs_vld & wb & (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Combinational source/destination compare for the OF-stage instruction.
// Build option PIPE_FWD_EN: forwarding present, only EX load-use stalls.
module pipe_hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_rs1_vld,
  input  logic              of_rs2_vld,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ma_rd,
  input  logic [REG_AW-1:0] rw_rd,
  input  logic              ex_wb,
  input  logic              ma_wb,
  input  logic              rw_wb,
  input  logic              ex_is_ld,
  output logic              hazard
);

  logic ex_match;
  logic ma_match;
  logic rw_match;

  assign ex_match = src_match(of_rs1, of_rs1_vld, ex_rd, ex_wb)
                  | src_match(of_rs2, of_rs2_vld, ex_rd, ex_wb);
  assign ma_match = src_match(of_rs1, of_rs1_vld, ma_rd, ma_wb)
                  | src_match(of_rs2, of_rs2_vld, ma_rd, ma_wb);
  assign rw_match = src_match(of_rs1, of_rs1_vld, rw_rd, rw_wb)
                  | src_match(of_rs2, of_rs2_vld, rw_rd, rw_wb);

`ifdef PIPE_FWD_EN
  // MA and RW results are forwarded; only a load still in EX cannot be.
  logic unused_late_match;
  assign unused_late_match = ma_match | rw_match;
  assign hazard = ex_match & ex_is_ld;
`else
  logic unused_is_ld;
  assign unused_is_ld = ex_is_ld;
  assign hazard = ex_match | ma_match | rw_match;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequencing controller for the IF/OF/EX/MA/RW pipeline: NOP fill after reset,
// hazard stalls, branch flushes, memory freeze with timeout. See PIPE_FWD_EN.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT    = 255,
  parameter int STARTUP_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] of_rs1,
  input  logic [REG_AW-1:0] of_rs2,
  input  logic              of_rs1_vld,
  input  logic              of_rs2_vld,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ma_rd,
  input  logic [REG_AW-1:0] rw_rd,
  input  logic              ex_wb,
  input  logic              ma_wb,
  input  logic              rw_wb,
  input  logic              ex_is_ld,
  input  logic              ex_branch_taken,
  input  logic              ma_mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              if_of_en,
  output logic              of_ex_en,
  output logic              ex_ma_en,
  output logic              ma_rw_en,
  output logic              if_of_flush,
  output logic              of_ex_bubble,
  output logic              ex_ma_bubble,
  output logic              ma_rw_bubble,
  output logic              mem_timeout,
  output logic [31:0]       stall_cycles
);

  pipe_ctrl_state_t state;
  pipe_ctrl_state_t state_nxt;
  pipe_ctl_t        ctl;

  logic [3:0] start_cnt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_inc;
  logic       hazard;
  logic       freeze;
  logic       active;
  logic       start_done;
  logic       wait_expired;

  pipe_hazard_detect u_detect (
    .of_rs1     (of_rs1),
    .of_rs2     (of_rs2),
    .of_rs1_vld (of_rs1_vld),
    .of_rs2_vld (of_rs2_vld),
    .ex_rd      (ex_rd),
    .ma_rd      (ma_rd),
    .rw_rd      (rw_rd),
    .ex_wb      (ex_wb),
    .ma_wb      (ma_wb),
    .rw_wb      (rw_wb),
    .ex_is_ld   (ex_is_ld),
    .hazard     (hazard)
  );

  assign freeze     = ma_mem_req & ~mem_ready;
  assign active     = (state == ST_RUN) || (state == ST_MEM_WAIT);
  assign start_done = (start_cnt == 4'(STARTUP_CYCLES - 1));

  // The first freeze cycle (still in RUN) counts as wait cycle one.
  assign wait_inc     = (state == ST_MEM_WAIT) ? wait_cnt + 8'd1 : 8'd1;
  assign wait_expired = active & freeze & (wait_inc == 8'(MEM_TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_STARTUP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STARTUP: begin
        if (start_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (wait_expired) begin
          state_nxt = ST_HALT;
        end else if (freeze) begin
          state_nxt = ST_MEM_WAIT;
        end else begin
          state_nxt = ST_RUN;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_STARTUP;
      end
    endcase
  end

  // A branch during a freeze is simply deferred: EX is held, so it reappears.
  always_comb begin
    ctl = CTL_HOLD;
    case (state)
      ST_STARTUP: begin
        ctl = CTL_FILL;
      end
      ST_RUN, ST_MEM_WAIT: begin
        if (freeze) begin
          ctl = CTL_HOLD;
        end else if (ex_branch_taken) begin
          ctl = CTL_BRANCH;
        end else if (hazard) begin
          ctl = CTL_STALL;
        end else begin
          ctl = CTL_PASS;
        end
      end
      default: begin
        ctl = CTL_HOLD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt <= 4'd0;
    end else if (state == ST_STARTUP && !start_done) begin
      start_cnt <= start_cnt + 4'd1;
    end else begin
      start_cnt <= 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'd0;
    end else if (active) begin
      wait_cnt <= freeze ? wait_inc : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_timeout <= 1'b0;
    end else if (wait_expired) begin
      mem_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 32'd0;
    end else if (active && !ctl.pc_en && stall_cycles != 32'hFFFF_FFFF) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

  assign pc_en        = ctl.pc_en;
  assign if_of_en     = ctl.if_of_en;
  assign of_ex_en     = ctl.of_ex_en;
  assign ex_ma_en     = ctl.ex_ma_en;
  assign ma_rw_en     = ctl.ma_rw_en;
  assign if_of_flush  = ctl.if_of_flush;
  assign of_ex_bubble = ctl.of_ex_bubble;
  assign ex_ma_bubble = ctl.ex_ma_bubble;
  assign ma_rw_bubble = ctl.ma_rw_bubble;

endmodule
